sii_l2t_req_issue: RTL

Inbound SII-to-L2 request issue stage. Accepts one decoded request descriptor at a time from the SII inbound queue, serializes it into 32-bit beats on the addressed L2 bank's request bus, and pulses that bank's request-valid on the first beat. Per-bank input-queue credits are tracked and returned by the L2 dequeue strobes. The block sits directly upstream of the L2 tag banks and drives the `sii_l2tN_req` / `sii_l2tN_req_vld` signals.

---
 rtl/sii_l2t_req_issue.sv | 102 ++++++++++
 1 files changed

// File: rtl/sii_l2t_req_issue.sv
// SII-to-L2 request issue stage: serializes one request descriptor into 32-bit
// beats on the addressed bank's lane and tracks per-bank L2 input-queue credits.
`timescale 1ns/1ps
module sii_l2t_req_issue #(
  parameter int IQ_DEPTH = 16,
  parameter int NBANK    = 8
) (
  input  logic         iol2clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_bank,
  input  logic         req_wr,
  input  logic [63:0]  req_hdr,
  input  logic [511:0] req_data,
  output logic [255:0] sii_l2t_req,
  output logic [7:0]   sii_l2t_req_vld,
  input  logic [7:0]   l2t_sii_iq_dequeue,
  output logic         credit_ovf
);

  localparam logic [7:0] CREDIT_MAX = 8'(IQ_DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  state_t       state;
  logic [4:0]   beat;
  logic [2:0]   cur_bank;
  logic         cur_wr;
  logic [63:0]  cur_hdr;
  logic [511:0] cur_data;
  logic [7:0]   credit [NBANK];

  logic         last_beat;
  logic         accept;
  logic [4:0]   dbeat;
  logic [511:0] data_shift;
  logic [31:0]  beat_word;

  assign last_beat = (state == SEND) && (beat == (cur_wr ? 5'd17 : 5'd1));
  // Ready looks only at the registered credit; a same-cycle dequeue is not counted.
  assign req_ready = ((state == IDLE) || last_beat) && (credit[req_bank] != 8'd0);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge iol2clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      beat       <= 5'd0;
      cur_bank   <= 3'd0;
      cur_wr     <= 1'b0;
      cur_hdr    <= 64'd0;
      cur_data   <= 512'd0;
      credit_ovf <= 1'b0;
      for (int b = 0; b < NBANK; b++) credit[b] <= CREDIT_MAX;
    end else begin
      if (accept) begin
        state    <= SEND;
        beat     <= 5'd0;
        cur_bank <= req_bank;
        cur_wr   <= req_wr;
        cur_hdr  <= req_hdr;
        cur_data <= req_data;
      end else if (last_beat) begin
        state <= IDLE;
        beat  <= 5'd0;
      end else if (state == SEND) begin
        beat <= beat + 5'd1;
      end

      for (int b = 0; b < NBANK; b++) begin
        case ({l2t_sii_iq_dequeue[b], accept && (req_bank == 3'(b))})
          2'b10: begin
            if (credit[b] == CREDIT_MAX) credit_ovf <= 1'b1;
            else                         credit[b]  <= credit[b] + 8'd1;
          end
          2'b01:   credit[b] <= credit[b] - 8'd1;
          default: ;
        endcase
      end
    end
  end

  // Data beat k sits at [511-32k -: 32]; shifting left brings it to the top word.
  assign dbeat      = beat - 5'd2;
  assign data_shift = cur_data << {dbeat[3:0], 5'd0};

  always_comb begin
    beat_word = data_shift[511:480];
    if (beat == 5'd0)      beat_word = cur_hdr[63:32];
    else if (beat == 5'd1) beat_word = cur_hdr[31:0];
  end

  always_comb begin
    sii_l2t_req     = '0;
    sii_l2t_req_vld = '0;
    if (state == SEND) begin
      sii_l2t_req[{cur_bank, 5'd0} +: 32] = beat_word;
      sii_l2t_req_vld[cur_bank]           = (beat == 5'd0);
    end
  end

endmodule
